// File: rtl/memory_map_slave.sv
// memory_map_slave
//
// Responder end of the single-cycle core's data-memory interface. Decodes a byte
// address (word access only, addr[1:0] ignored) into:
//   0x1001_0000 + 4*i  data RAM, i < RAM_WORDS, read/write
//   0x1001_0400        GPIO_OUT, read/write (low GPIO_WIDTH bits)
//   0x1001_0404        GPIO_IN, read-only, two-flop synchronized
//   0x1001_0408        UART_TX, write-only, starts an 8N1 frame when idle
//   0x1001_040C        UART_STAT, read-only, bit0 = uart_busy
// Anything else reads 0 and ignores writes. Read data is combinational (zero
// latency); writes commit on the rising edge of clk when mem_write is high.
//
// Ports:
//   clk        system clock, rising edge
//   n_rst      synchronous active-low reset
//   mem_write  write strobe from the core
//   addr       byte address
//   wdata      write data
//   rdata      combinational read data for addr
//   gpio_in    asynchronous external inputs
//   gpio_out   registered GPIO outputs
//   uart_tx    UART serial line, idle high
//   uart_busy  high while a frame is in progress

module memory_map_slave #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned RAM_WORDS    = 64,
   parameter int unsigned GPIO_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   input  logic [GPIO_WIDTH-1:0] gpio_in,
   output logic [GPIO_WIDTH-1:0] gpio_out,
   output logic                  uart_tx,
   output logic                  uart_busy
);

   localparam int unsigned RamAw = $clog2(RAM_WORDS);
   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [ADDR_WIDTH-1:0] RamBase      = ADDR_WIDTH'(32'h1001_0000);
   localparam logic [ADDR_WIDTH-1:0] RamEnd       = ADDR_WIDTH'(32'h1001_0000 + 4 * RAM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] GpioOutAddr  = ADDR_WIDTH'(32'h1001_0400);
   localparam logic [ADDR_WIDTH-1:0] GpioInAddr   = ADDR_WIDTH'(32'h1001_0404);
   localparam logic [ADDR_WIDTH-1:0] UartTxAddr   = ADDR_WIDTH'(32'h1001_0408);
   localparam logic [ADDR_WIDTH-1:0] UartStatAddr = ADDR_WIDTH'(32'h1001_040C);

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [RamAw-1:0]      ram_idx;
   logic                  sel_ram;
   logic                  sel_gpio_out;
   logic                  sel_gpio_in;
   logic                  sel_uart_tx;
   logic                  sel_uart_stat;
   logic                  sel_periph;
   logic                  wr_en;
   logic                  unused_addr_lsb;

   assign word_addr       = {addr[ADDR_WIDTH-1:2], 2'b00};
   assign ram_idx         = addr[RamAw+1:2];
   assign unused_addr_lsb = ^addr[1:0];

   // Writes are only honoured out of reset, for every target.
   assign wr_en = n_rst & mem_write;

   always_comb begin
      sel_gpio_out  = (word_addr == GpioOutAddr);
      sel_gpio_in   = (word_addr == GpioInAddr);
      sel_uart_tx   = (word_addr == UartTxAddr);
      sel_uart_stat = (word_addr == UartStatAddr);
      sel_periph    = sel_gpio_out | sel_gpio_in | sel_uart_tx | sel_uart_stat;
      // Full range compare so the gap above the RAM never aliases onto it. The
      // peripheral window wins if a very deep RAM would overlap it.
      sel_ram       = (word_addr >= RamBase) && (word_addr < RamEnd) && !sel_periph;
   end

   // ---------------------------------------------------------------------------
   // Data RAM: not reset, asynchronous read, synchronous write
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] ram_q [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (wr_en && sel_ram) begin
         ram_q[ram_idx] <= wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // GPIO: output register and two-flop input synchronizer
   // ---------------------------------------------------------------------------
   logic [GPIO_WIDTH-1:0] gpio_out_q;
   logic [GPIO_WIDTH-1:0] gpio_meta_q;
   logic [GPIO_WIDTH-1:0] gpio_sync_q;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         gpio_out_q  <= '0;
         gpio_meta_q <= '0;
         gpio_sync_q <= '0;
      end else begin
         gpio_meta_q <= gpio_in;
         gpio_sync_q <= gpio_meta_q;
         if (mem_write && sel_gpio_out) begin
            gpio_out_q <= wdata[GPIO_WIDTH-1:0];
         end
      end
   end

   assign gpio_out = gpio_out_q;

   // ---------------------------------------------------------------------------
   // UART transmitter, 8N1, LSB first
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } uart_state_e;

   uart_state_e      state_q;
   logic [BaudW-1:0] baud_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic             tx_q;
   logic             busy_q;
   logic             baud_done;
   logic             tx_write;

   assign baud_done = (baud_q == BaudW'(CLKS_PER_BIT - 1));
   assign tx_write  = wr_en & sel_uart_tx;

   // tx_q and busy_q are set on the transition edge so they line up exactly
   // with the state they describe: 10*CLKS_PER_BIT busy cycles per frame.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q   <= StIdle;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (tx_write) begin
                  shift_q   <= wdata[7:0];
                  baud_q    <= '0;
                  bit_idx_q <= '0;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= StStart;
               end
            end
            StStart: begin
               if (baud_done) begin
                  baud_q    <= '0;
                  bit_idx_q <= '0;
                  tx_q      <= shift_q[0];
                  state_q   <= StData;
               end else begin
                  baud_q <= baud_q + BaudW'(1);
               end
            end
            StData: begin
               if (baud_done) begin
                  baud_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     tx_q      <= shift_q[bit_idx_q + 3'd1];
                  end
               end else begin
                  baud_q <= baud_q + BaudW'(1);
               end
            end
            StStop: begin
               if (baud_done) begin
                  baud_q  <= '0;
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  baud_q <= baud_q + BaudW'(1);
               end
            end
            default: begin
               state_q <= StIdle;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign uart_tx   = tx_q;
   assign uart_busy = busy_q;

   // ---------------------------------------------------------------------------
   // Read mux: combinational, no side effects, not gated by mem_write
   // ---------------------------------------------------------------------------
   always_comb begin
      rdata = '0;
      if (sel_ram) begin
         rdata = ram_q[ram_idx];
      end else if (sel_gpio_out) begin
         rdata = DATA_WIDTH'(gpio_out_q);
      end else if (sel_gpio_in) begin
         rdata = DATA_WIDTH'(gpio_sync_q);
      end else if (sel_uart_stat) begin
         rdata[0] = busy_q;
      end
   end

endmodule

// File: tb/tb_memory_map_slave.sv
// Bench for memory_map_slave: table of directed vectors, hand sequences for the
// GPIO synchronizer and UART frames, and a randomized run checked every cycle
// against a behavioural model (RAM array, GPIO delay line, UART waveform queue).

module tb_memory_map_slave;

   localparam int unsigned CPB = 4;
   localparam int unsigned RW  = 64;

   localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
   localparam logic [31:0] GPIO_OUT  = 32'h1001_0400;
   localparam logic [31:0] GPIO_IN   = 32'h1001_0404;
   localparam logic [31:0] UART_TX   = 32'h1001_0408;
   localparam logic [31:0] UART_STAT = 32'h1001_040C;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic        uart_tx;
   logic        uart_busy;

   memory_map_slave #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .RAM_WORDS   (RW),
      .GPIO_WIDTH  (8),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .mem_write(mem_write),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .uart_tx  (uart_tx),
      .uart_busy(uart_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- behavioural model ----------------
   logic [31:0] m_ram   [RW];
   bit          m_valid [RW];
   logic [7:0]  m_gpio_out = '0;
   logic [7:0]  m_gin_prev = '0;  // gpio_in seen at the last edge
   logic [7:0]  m_gin_vis  = '0;  // gpio_in seen two edges ago
   bit          m_tx_q[$];        // expected uart_tx, one entry per remaining frame cycle

   function automatic bit in_ram(input logic [31:0] w);
      return (w >= RAM_BASE) && (w < RAM_BASE + 32'(4 * RW));
   endfunction

   function automatic bit m_busy();
      return m_tx_q.size() != 0;
   endfunction

   function automatic bit m_tx();
      return (m_tx_q.size() != 0) ? m_tx_q[0] : 1'b1;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
      logic [31:0] w;
      int          idx;
      w     = {a[31:2], 2'b00};
      known = 1'b1;
      if (in_ram(w)) begin
         idx   = int'((w - RAM_BASE) >> 2);
         known = m_valid[idx];
         return m_ram[idx];
      end
      if (w == GPIO_OUT)  return {24'h0, m_gpio_out};
      if (w == GPIO_IN)   return {24'h0, m_gin_vis};
      if (w == UART_STAT) return {31'h0, m_busy()};
      return 32'h0;
   endfunction

   // Applied once per rising edge with the inputs of the cycle just ending.
   task automatic model_edge();
      logic [31:0] w;
      bit          accept;
      int          idx;
      if (!n_rst) begin
         m_gpio_out = '0;
         m_gin_prev = '0;
         m_gin_vis  = '0;
         m_tx_q.delete();
         return;
      end
      m_gin_vis  = m_gin_prev;
      m_gin_prev = gpio_in;
      w      = {addr[31:2], 2'b00};
      accept = mem_write && (w == UART_TX) && (m_tx_q.size() == 0);
      if (mem_write) begin
         if (in_ram(w)) begin
            idx          = int'((w - RAM_BASE) >> 2);
            m_ram[idx]   = wdata;
            m_valid[idx] = 1'b1;
         end else if (w == GPIO_OUT) begin
            m_gpio_out = wdata[7:0];
         end
      end
      if (m_tx_q.size() != 0) void'(m_tx_q.pop_front());
      if (accept) begin
         for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < int'(CPB); k++) begin
               m_tx_q.push_back((b == 0) ? 1'b0 : (b == 9) ? 1'b1 : wdata[b-1]);
            end
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check_all();
      bit          known;
      logic [31:0] exp;
      chk("uart_tx", 32'(uart_tx), 32'(m_tx()));
      chk("uart_busy", 32'(uart_busy), 32'(m_busy()));
      chk("gpio_out", 32'(gpio_out), 32'(m_gpio_out));
      exp = m_read(addr, known);
      if (known) chk("rdata", rdata, exp);
   endtask

   task automatic edge_adv();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic finish_cycle();
      check_all();
      edge_adv();
   endtask

   task automatic step();
      #3;
      finish_cycle();
   endtask

   // Write byte b to UART_TX, then watch the full frame. A second write of 0xFF
   // is injected at frame cycle drop_at (if in range) and must be ignored.
   task automatic send_and_watch(input logic [7:0] b, input int drop_at);
      bit exp_bit;
      int bit_no;
      mem_write = 1'b1;
      addr      = UART_TX;
      wdata     = {24'hABCDEF, b};
      #3;
      chk("tx_pre_busy", 32'(uart_busy), 32'd0);
      chk("tx_pre_line", 32'(uart_tx), 32'd1);
      finish_cycle();
      for (int c = 0; c < 10 * int'(CPB); c++) begin
         if (c == drop_at) begin
            mem_write = 1'b1;
            addr      = UART_TX;
            wdata     = 32'h0000_00FF;
         end else begin
            mem_write = 1'b0;
            addr      = UART_STAT;
         end
         bit_no  = c / int'(CPB);
         exp_bit = (bit_no == 0) ? 1'b0 : (bit_no == 9) ? 1'b1 : b[bit_no-1];
         #3;
         chk($sformatf("tx_bit c%0d", c), 32'(uart_tx), 32'(exp_bit));
         chk($sformatf("tx_busy c%0d", c), 32'(uart_busy), 32'd1);
         if (addr == UART_STAT) chk($sformatf("tx_stat c%0d", c), rdata, 32'd1);
         finish_cycle();
      end
      mem_write = 1'b0;
      addr      = UART_STAT;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit          we;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [20];

   initial begin
      logic [7:0] mid_byte;
      int         sel;

      vecs[0]  = '{1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 32'h0000_0000};
      vecs[1]  = '{1'b1, 32'h1001_00FC, 32'h0000_1234, 32'h0000_0000};
      vecs[2]  = '{1'b0, 32'h1001_0000, 32'h0000_0000, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b0, 32'h1001_00FC, 32'h0000_0000, 32'h0000_1234};
      vecs[4]  = '{1'b0, 32'h1001_0100, 32'h0000_0000, 32'h0000_0000};
      vecs[5]  = '{1'b1, 32'h1001_0100, 32'hBAD0_BAD0, 32'h0000_0000};
      vecs[6]  = '{1'b0, 32'h1001_0000, 32'h0000_0000, 32'hDEAD_BEEF};
      vecs[7]  = '{1'b0, 32'h1001_0100, 32'h0000_0000, 32'h0000_0000};
      vecs[8]  = '{1'b1, 32'h1001_0400, 32'hFFFF_FFA5, 32'h0000_0000};
      vecs[9]  = '{1'b0, 32'h1001_0400, 32'h0000_0000, 32'h0000_00A5};
      vecs[10] = '{1'b0, 32'h1001_0402, 32'h0000_0000, 32'h0000_00A5};
      vecs[11] = '{1'b1, 32'h1001_0404, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[12] = '{1'b0, 32'h1001_0404, 32'h0000_0000, 32'h0000_0000};
      vecs[13] = '{1'b0, 32'h1001_040C, 32'h0000_0000, 32'h0000_0000};
      vecs[14] = '{1'b0, 32'h1001_0408, 32'h0000_0000, 32'h0000_0000};
      vecs[15] = '{1'b1, 32'h1002_0000, 32'h1234_5678, 32'h0000_0000};
      vecs[16] = '{1'b0, 32'h1002_0000, 32'h0000_0000, 32'h0000_0000};
      vecs[17] = '{1'b1, 32'h1001_00FC, 32'hCAFE_F00D, 32'h0000_1234};
      vecs[18] = '{1'b0, 32'h1001_00FF, 32'h0000_0000, 32'hCAFE_F00D};
      vecs[19] = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 32'h0000_0000};

      n_rst     = 1'b0;
      mem_write = 1'b0;
      addr      = GPIO_IN;
      wdata     = '0;
      gpio_in   = 8'h00;
      edge_adv();
      edge_adv();

      // Reset state.
      #3;
      chk("rst_uart_tx", 32'(uart_tx), 32'd1);
      chk("rst_uart_busy", 32'(uart_busy), 32'd0);
      chk("rst_gpio_out", 32'(gpio_out), 32'd0);
      chk("rst_gpio_in_rd", rdata, 32'd0);
      finish_cycle();
      n_rst = 1'b1;

      // Give every RAM word a known value.
      for (int i = 0; i < int'(RW); i++) begin
         mem_write = 1'b1;
         addr      = RAM_BASE + 32'(4 * i);
         wdata     = 32'h0;
         step();
      end
      mem_write = 1'b0;

      foreach (vecs[i]) begin
         mem_write = vecs[i].we;
         addr      = vecs[i].a;
         wdata     = vecs[i].d;
         #3;
         chk($sformatf("vec%0d", i), rdata, vecs[i].exp);
         finish_cycle();
      end
      mem_write = 1'b0;
      chk("gpio_out_a5", 32'(gpio_out), 32'h0000_00A5);

      // Writes during reset are ignored; reset clears gpio_out.
      n_rst     = 1'b0;
      mem_write = 1'b1;
      addr      = GPIO_OUT;
      wdata     = 32'h0000_00FF;
      step();
      addr  = RAM_BASE;
      wdata = 32'h1111_1111;
      step();
      n_rst     = 1'b1;
      mem_write = 1'b0;
      #3;
      chk("gpio_out_after_rst", 32'(gpio_out), 32'd0);
      chk("ram_wr_in_rst", rdata, 32'hDEAD_BEEF);
      finish_cycle();

      // GPIO_IN synchronizer latency.
      addr    = GPIO_IN;
      gpio_in = 8'h3C;
      #3;
      chk("gin_t", rdata, 32'd0);
      finish_cycle();
      #3;
      chk("gin_t1", rdata, 32'd0);
      finish_cycle();
      #3;
      chk("gin_t2", rdata, 32'h0000_003C);
      finish_cycle();

      // UART frame of 0x55 with a dropped write, then back-to-back 0x0F.
      send_and_watch(8'h55, 10);
      send_and_watch(8'h0F, -1);
      #3;
      chk("tx_end_busy", 32'(uart_busy), 32'd0);
      chk("tx_end_line", 32'(uart_tx), 32'd1);
      chk("tx_end_stat", rdata, 32'd0);
      finish_cycle();

      // Reset in the middle of data bit 3.
      mid_byte  = 8'hA3;
      mem_write = 1'b1;
      addr      = UART_TX;
      wdata     = {24'h0, mid_byte};
      step();
      mem_write = 1'b0;
      addr      = UART_STAT;
      for (int c = 0; c < 4 * int'(CPB) + 1; c++) step();
      #3;
      chk("mid_bit3", 32'(uart_tx), 32'(mid_byte[3]));
      n_rst = 1'b0;
      finish_cycle();
      n_rst = 1'b1;
      #3;
      chk("rst_mid_tx", 32'(uart_tx), 32'd1);
      chk("rst_mid_busy", 32'(uart_busy), 32'd0);
      finish_cycle();
      send_and_watch(8'hC6, -1);
      step();

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         n_rst     = ($urandom_range(0, 199) != 0);
         mem_write = 1'($urandom_range(0, 1));
         wdata     = $urandom();
         sel       = int'($urandom_range(0, 7));
         case (sel)
            0, 1: addr = RAM_BASE + 32'(4 * $urandom_range(0, RW - 1)) + 32'($urandom_range(0, 3));
            2: addr = 32'h1001_0100 + 32'(4 * $urandom_range(0, 191));
            3: addr = GPIO_OUT;
            4: addr = GPIO_IN;
            5: addr = UART_TX;
            6: addr = UART_STAT;
            default: addr = $urandom();
         endcase
         if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom());
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
